// File: rtl/eth_rx_header_parser_if.sv
// Signal bundle for eth_rx_header_parser: MAC-side byte stream in, header
// handshake and payload stream out, plus drop status.
interface eth_rx_header_parser_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [47:0] hdr_dst_mac;
  logic [47:0] hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_dropped;
  logic        short_frame;
  logic [15:0] drop_count;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  hdr_ready, m_axis_tready,
    output s_axis_tready, hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_ethertype,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output frame_dropped, short_frame, drop_count
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output hdr_ready, m_axis_tready,
    input  s_axis_tready, hdr_valid, hdr_dst_mac, hdr_src_mac, hdr_ethertype,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  frame_dropped, short_frame, drop_count
  );
endinterface

// File: rtl/eth_rx_header_parser.sv
// Ethernet RX header parser: captures dst/src/EtherType, filters on destination
// MAC, forwards accepted payload as a pass-through stream and counts drops.
module eth_rx_header_parser #(
  parameter logic [47:0] LOCAL_MAC        = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BROADCAST = 1'b1,
  parameter bit          ACCEPT_MULTICAST = 1'b0,
  parameter bit          PROMISCUOUS      = 1'b0
) (
  input logic                   clk,
  input logic                   reset,
  eth_rx_header_parser_if.slave bus
);

  typedef enum logic [1:0] {
    S_HEADER,
    S_WAIT_HDR,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic        dropped_q, dropped_d;
  logic        short_q, short_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        s_fire;
  logic        accept;
  logic        count_drop;

  // dst_q is complete by the time the last header byte (index 13) arrives
  always_comb begin
    accept = PROMISCUOUS
          || (dst_q == LOCAL_MAC)
          || (ACCEPT_BROADCAST && (dst_q == '1))
          || (ACCEPT_MULTICAST && dst_q[40]);
  end

  // Handshake outputs are gated by reset so the reset cycle itself is quiet
  always_comb begin
    bus.s_axis_tready = 1'b0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tuser  = 1'b0;
    bus.m_axis_tdata  = bus.s_axis_tdata;
    if (reset) begin
      case (state_q)
        S_HEADER, S_DROP: bus.s_axis_tready = 1'b1;
        S_PAYLOAD: begin
          bus.s_axis_tready = bus.m_axis_tready;
          bus.m_axis_tvalid = bus.s_axis_tvalid;
          bus.m_axis_tlast  = bus.s_axis_tlast;
          bus.m_axis_tuser  = bus.s_axis_tuser;
        end
        default: ;
      endcase
    end
  end

  assign bus.hdr_valid     = reset && (state_q == S_WAIT_HDR);
  assign bus.hdr_dst_mac   = dst_q;
  assign bus.hdr_src_mac   = src_q;
  assign bus.hdr_ethertype = type_q;
  assign bus.frame_dropped = dropped_q;
  assign bus.short_frame   = short_q;
  assign bus.drop_count    = drop_cnt_q;

  assign s_fire = bus.s_axis_tvalid && bus.s_axis_tready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dst_d      = dst_q;
    src_d      = src_q;
    type_d     = type_q;
    dropped_d  = 1'b0;
    short_d    = 1'b0;
    count_drop = 1'b0;
    case (state_q)
      S_HEADER: begin
        if (s_fire) begin
          if (idx_q < 4'd6)       dst_d  = {dst_q[39:0], bus.s_axis_tdata};
          else if (idx_q < 4'd12) src_d  = {src_q[39:0], bus.s_axis_tdata};
          else                    type_d = {type_q[7:0], bus.s_axis_tdata};
          if (bus.s_axis_tlast) begin
            short_d    = 1'b1;
            dropped_d  = 1'b1;
            count_drop = 1'b1;
            idx_d      = '0;
          end else if (idx_q == 4'd13) begin
            idx_d   = '0;
            state_d = accept ? S_WAIT_HDR : S_DROP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WAIT_HDR: begin
        if (bus.hdr_ready) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (s_fire && bus.s_axis_tlast) state_d = S_HEADER;
      end
      S_DROP: begin
        if (s_fire && bus.s_axis_tlast) begin
          dropped_d  = 1'b1;
          count_drop = 1'b1;
          state_d    = S_HEADER;
        end
      end
      default: state_d = S_HEADER;
    endcase
    drop_cnt_d = (count_drop && (drop_cnt_q != '1)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_HEADER;
      idx_q      <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      type_q     <= '0;
      dropped_q  <= 1'b0;
      short_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dst_q      <= dst_d;
      src_q      <= src_d;
      type_q     <= type_d;
      dropped_q  <= dropped_d;
      short_q    <= short_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_eth_rx_header_parser.sv
// Scoreboard bench for eth_rx_header_parser: directed frames push expected
// headers, payload beats and drop pulses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_eth_rx_header_parser;

  logic clk;
  logic reset;

  eth_rx_header_parser_if bus();

  eth_rx_header_parser #(
    .LOCAL_MAC       (48'h02_00_00_00_00_01),
    .ACCEPT_BROADCAST(1'b1),
    .ACCEPT_MULTICAST(1'b0),
    .PROMISCUOUS     (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
  } hdr_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  hdr_t        hdr_q[$];
  beat_t       beat_q[$];
  bit          drop_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_drops = 0;
  int unsigned hdr_hold = 0;
  int unsigned stall_cycles = 0;
  bit          rand_tready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT", name);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "aborting");
  endtask

  // hdr_ready: stall hdr_hold cycles once hdr_valid is seen, then accept
  initial begin
    int unsigned cnt = 0;
    bus.hdr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.hdr_valid) begin
        if (cnt < hdr_hold) begin
          bus.hdr_ready = 1'b0;
          cnt++;
        end else begin
          bus.hdr_ready = 1'b1;
        end
      end else begin
        cnt = 0;
        bus.hdr_ready = (hdr_hold == 0);
      end
    end
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  initial begin
    bit   prev_stall = 1'b0;
    hdr_t prev_h;
    hdr_t h;
    beat_t b;
    bit   s;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("hdr_held_valid", 64'(bus.hdr_valid), 64'(1'b1));
        check("hdr_held_dst", 64'(bus.hdr_dst_mac), 64'(prev_h.dst));
        check("hdr_held_src", 64'(bus.hdr_src_mac), 64'(prev_h.src));
        check("hdr_held_type", 64'(bus.hdr_ethertype), 64'(prev_h.etype));
      end
      if (bus.hdr_valid) begin
        check("wait_hdr_s_tready", 64'(bus.s_axis_tready), 64'(1'b0));
        if (bus.hdr_ready) begin
          if (hdr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_hdr: got dst %0h expected none", bus.hdr_dst_mac);
          end else begin
            h = hdr_q.pop_front();
            check("hdr_dst", 64'(bus.hdr_dst_mac), 64'(h.dst));
            check("hdr_src", 64'(bus.hdr_src_mac), 64'(h.src));
            check("hdr_type", 64'(bus.hdr_ethertype), 64'(h.etype));
          end
        end
      end
      prev_stall = bus.hdr_valid && !bus.hdr_ready;
      prev_h     = '{dst: bus.hdr_dst_mac, src: bus.hdr_src_mac, etype: bus.hdr_ethertype};

      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (beat_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got %0h expected none", bus.m_axis_tdata);
        end else begin
          b = beat_q.pop_front();
          check("beat_data", 64'(bus.m_axis_tdata), 64'(b.data));
          check("beat_last", 64'(bus.m_axis_tlast), 64'(b.last));
          check("beat_user", 64'(bus.m_axis_tuser), 64'(b.user));
        end
      end

      if (bus.frame_dropped) begin
        if (drop_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_drop: got frame_dropped=1 expected 0");
        end else begin
          s = drop_q.pop_front();
          check("drop_short_flag", 64'(bus.short_frame), 64'(s));
        end
      end else if (bus.short_frame) begin
        tests++; fails++;
        $display("FAIL short_without_drop: got short_frame=1 expected 0");
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int unsigned n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    bus.s_axis_tuser  = user;
    @(negedge clk);
    while (!bus.s_axis_tready) begin
      n++;
      if (n > 1000) fail_now("s_axis_accept");
      @(negedge clk);
    end
    stall_cycles = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  // kind: 0 accept, 1 filter drop, 2 short frame truncated to short_len bytes
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] et, input int unsigned npay,
                            input logic [7:0] start, input logic user,
                            input int unsigned kind, input int unsigned short_len,
                            output int unsigned first_wait);
    logic [7:0]  bytes[$];
    int unsigned n;
    for (int i = 0; i < 6; i++) bytes.push_back(dst[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) bytes.push_back(src[47 - 8*i -: 8]);
    bytes.push_back(et[15:8]);
    bytes.push_back(et[7:0]);
    for (int i = 0; i < int'(npay); i++) bytes.push_back(start + 8'(i));
    n = (kind == 2) ? short_len : bytes.size();
    if (kind == 0) begin
      hdr_q.push_back('{dst: dst, src: src, etype: et});
      for (int i = 0; i < int'(npay); i++)
        beat_q.push_back('{data: start + 8'(i), last: (i == int'(npay) - 1),
                           user: (i == int'(npay) - 1) ? user : 1'b0});
    end else begin
      drop_q.push_back(kind == 2);
    end
    for (int i = 0; i < int'(n); i++) begin
      send_byte(bytes[i], i == int'(n) - 1, (i == int'(n) - 1) ? user : 1'b0);
      if (i == 0) first_wait = stall_cycles;
    end
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    idle();
    while (hdr_q.size() != 0 || beat_q.size() != 0 || drop_q.size() != 0) begin
      n++;
      if (n > 2000) fail_now(name);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_drop_count"}, 64'(bus.drop_count), 64'(exp_drops));
  endtask

  initial begin
    #1_500_000;
    fail_now("global_watchdog");
  end

  initial begin
    int unsigned fw;
    reset = 1'b0;
    idle();
    bus.s_axis_tdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 64'(bus.s_axis_tready), 64'(1'b0));
    check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'(1'b0));
    @(posedge clk);
    #1;
    check("rst_hdr_valid", 64'(bus.hdr_valid), 64'(1'b0));
    check("rst_hdr_dst", 64'(bus.hdr_dst_mac), 64'(0));
    check("rst_drop_count", 64'(bus.drop_count), 64'(0));
    check("rst_frame_dropped", 64'(bus.frame_dropped), 64'(1'b0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Unicast accept
    send_frame(48'h02_00_00_00_00_01, 48'h00_11_22_33_44_55, 16'h0800, 46, 8'h00, 1'b0, 0, 0, fw);
    drain("unicast");

    // Filter reject, 60-byte frame
    send_frame(48'h02_00_00_00_00_99, 48'h00_11_22_33_44_55, 16'h0800, 46, 8'h00, 1'b0, 1, 0, fw);
    exp_drops = 1;
    drain("reject");

    // Broadcast accept
    send_frame(48'hff_ff_ff_ff_ff_ff, 48'h00_aa_bb_cc_dd_ee, 16'h0806, 28, 8'h40, 1'b0, 0, 0, fw);
    drain("broadcast");

    // Short frames: tlast on byte 9 then on byte 13, then a normal frame
    send_frame(48'h02_00_00_00_00_01, 48'h00_11_22_33_44_55, 16'h0800, 46, 8'h00, 1'b0, 2, 10, fw);
    send_frame(48'h02_00_00_00_00_01, 48'h00_11_22_33_44_55, 16'h0800, 46, 8'h00, 1'b0, 2, 14, fw);
    send_frame(48'h02_00_00_00_00_01, 48'h66_77_88_99_aa_bb, 16'h86dd, 8, 8'h80, 1'b0, 0, 0, fw);
    exp_drops = 3;
    drain("short");

    // Multicast destination rejected when multicast acceptance is off
    send_frame(48'h01_00_5e_00_00_01, 48'h00_11_22_33_44_55, 16'h0800, 46, 8'h00, 1'b0, 1, 0, fw);
    exp_drops = 4;
    drain("multicast");

    // Backpressure on header and payload
    hdr_hold = 20;
    rand_tready = 1'b1;
    send_frame(48'h02_00_00_00_00_01, 48'h12_34_56_78_9a_bc, 16'h0800, 40, 8'hc0, 1'b0, 0, 0, fw);
    drain("backpressure");
    hdr_hold = 0;
    rand_tready = 1'b0;

    // Bad FCS frame followed back-to-back by a good one
    send_frame(48'h02_00_00_00_00_01, 48'h00_11_22_33_44_55, 16'h0800, 20, 8'h10, 1'b1, 0, 0, fw);
    send_frame(48'h02_00_00_00_00_01, 48'h00_de_ad_be_ef_00, 16'h0801, 12, 8'h50, 1'b0, 0, 0, fw);
    check("b2b_no_bubble", 64'(fw), 64'(0));
    drain("badfcs_b2b");

    // Reset at payload byte 10
    begin
      logic [7:0] rb[$];
      logic [47:0] d = 48'h02_00_00_00_00_01;
      logic [47:0] sm = 48'h00_11_22_33_44_55;
      for (int i = 0; i < 6; i++) rb.push_back(d[47 - 8*i -: 8]);
      for (int i = 0; i < 6; i++) rb.push_back(sm[47 - 8*i -: 8]);
      rb.push_back(8'h08);
      rb.push_back(8'h00);
      for (int i = 0; i < 20; i++) rb.push_back(8'(i));
      hdr_q.push_back('{dst: d, src: sm, etype: 16'h0800});
      for (int i = 0; i < 10; i++) beat_q.push_back('{data: 8'(i), last: 1'b0, user: 1'b0});
      for (int i = 0; i < 24; i++) send_byte(rb[i], 1'b0, 1'b0);
      bus.s_axis_tdata = rb[24];
      reset = 1'b0;
      @(negedge clk);
      check("midrst_s_tready", 64'(bus.s_axis_tready), 64'(1'b0));
      check("midrst_m_tvalid", 64'(bus.m_axis_tvalid), 64'(1'b0));
      @(posedge clk);
      #1;
      check("midrst_hdr_valid", 64'(bus.hdr_valid), 64'(1'b0));
      check("midrst_hdr_dst", 64'(bus.hdr_dst_mac), 64'(0));
      check("midrst_hdr_src", 64'(bus.hdr_src_mac), 64'(0));
      check("midrst_hdr_type", 64'(bus.hdr_ethertype), 64'(0));
      check("midrst_drop_count", 64'(bus.drop_count), 64'(0));
      check("midrst_frame_dropped", 64'(bus.frame_dropped), 64'(1'b0));
      check("midrst_short_frame", 64'(bus.short_frame), 64'(1'b0));
      reset = 1'b1;
      exp_drops = 0;
      drain("midreset");
    end

    // Saturation with one-byte frames
    for (int i = 0; i < 65535; i++) begin
      drop_q.push_back(1'b1);
      send_byte(8'hAA, 1'b1, 1'b0);
    end
    exp_drops = 16'hFFFF;
    drain("sat_reach");
    for (int i = 0; i < 5; i++) begin
      drop_q.push_back(1'b1);
      send_byte(8'h55, 1'b1, 1'b0);
    end
    drain("sat_hold");

    check("end_hdr_q_empty", 64'(hdr_q.size()), 64'(0));
    check("end_beat_q_empty", 64'(beat_q.size()), 64'(0));
    check("end_drop_q_empty", 64'(drop_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
